// File: rtl/door_game_pkg.sv
// Shared types and helpers for the door-guessing game round controller.
// Width functions keep every instantiating module consistent.
package door_game_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSelect   = 3'd1,
    StReveal   = 3'd2,
    StScore    = 3'd3,
    StGameOver = 3'd4
  } state_t;

  // Fibonacci feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic int unsigned door_width(input int unsigned num_doors);
    return (num_doors > 1) ? $clog2(num_doors) : 1;
  endfunction

  function automatic int unsigned life_width(input int unsigned max_lives);
    return $clog2(max_lives + 1);
  endfunction

  function automatic int unsigned player_width(input int unsigned num_players);
    return (num_players > 1) ? $clog2(num_players) : 1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return {value[14:0], ^(value & LfsrTaps)};
  endfunction

endpackage

// File: rtl/round_timer.sv
// Round countdown: sub-second tick counter plus the displayed seconds value.
// load re-arms the round; enable lets time pass.
module round_timer #(
  parameter int unsigned TICKS_PER_SEC = 25000000,
  parameter int unsigned ROUND_SECONDS = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic       i_enable,
  output logic       o_sec_pulse,
  output logic       o_expired,
  output logic [5:0] o_seconds_left
);

  localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TickW-1:0] TickMax = TickW'(TICKS_PER_SEC - 1);
  localparam logic [5:0] SecInit = 6'(ROUND_SECONDS);

  logic [TickW-1:0] r_ticks;
  logic [5:0]       r_secs;

  assign o_sec_pulse    = i_enable && (r_ticks == TickMax);
  // Level flag: the final second is running, so the next pulse ends the round.
  assign o_expired      = (r_secs == 6'd1);
  assign o_seconds_left = r_secs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ticks <= '0;
      r_secs  <= SecInit;
    end else if (i_load) begin
      r_ticks <= '0;
      r_secs  <= SecInit;
    end else if (i_enable) begin
      if (r_ticks == TickMax) begin
        r_ticks <= '0;
        if (r_secs != 6'd0) begin
          r_secs <= r_secs - 6'd1;
        end
      end else begin
        r_ticks <= r_ticks + TickW'(1);
      end
    end
  end

endmodule

// File: rtl/door_game_ctrl.sv
// Round controller for the door-guessing game: lives, correct door, reveal flag.
// Owns the LFSR door picker, per-player choice locks and the game FSM.
module door_game_ctrl
  import door_game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned NUM_DOORS     = 4,
  parameter int unsigned MAX_LIVES     = 3,
  parameter int unsigned TICKS_PER_SEC = 25000000,
  parameter int unsigned ROUND_SECONDS = 10,
  parameter int unsigned REVEAL_TICKS  = 50000000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  localparam int unsigned DOOR_W       = door_width(NUM_DOORS),
  localparam int unsigned LIFE_W       = life_width(MAX_LIVES),
  localparam int unsigned PLAYER_W     = player_width(NUM_PLAYERS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [NUM_PLAYERS*DOOR_W-1:0] i_choice,
  input  logic [NUM_PLAYERS-1:0]        i_choice_valid,
  output logic [NUM_PLAYERS*LIFE_W-1:0] o_lives,
  output logic [DOOR_W-1:0]             o_correct_door,
  output logic                          o_time_up,
  output logic [5:0]                    o_seconds_left,
  output logic [2:0]                    o_state,
  output logic [PLAYER_W-1:0]           o_winner,
  output logic                          o_draw
);

  localparam int unsigned RevW = (REVEAL_TICKS > 1) ? $clog2(REVEAL_TICKS) : 1;
  localparam logic [RevW-1:0] RevMax = RevW'(REVEAL_TICKS - 1);
  localparam int unsigned CntW = $clog2(NUM_PLAYERS + 1);
  localparam logic [LIFE_W-1:0] LivesInit = LIFE_W'(MAX_LIVES);

  state_t                               r_state;
  logic [15:0]                          r_lfsr;
  logic [NUM_PLAYERS-1:0][LIFE_W-1:0]   r_lives;
  logic [NUM_PLAYERS-1:0][DOOR_W-1:0]   r_pick;
  logic [NUM_PLAYERS-1:0]               r_lock;
  logic [DOOR_W-1:0]                    r_door;
  logic                                 r_time_up;
  logic [RevW-1:0]                      r_rev_cnt;
  logic [PLAYER_W-1:0]                  r_winner;
  logic                                 r_draw;

  logic [NUM_PLAYERS-1:0][DOOR_W-1:0]   w_choice;
  logic [NUM_PLAYERS-1:0]               w_alive;
  logic [NUM_PLAYERS-1:0]               w_lock_next;
  logic [NUM_PLAYERS-1:0][LIFE_W-1:0]   w_lives_scored;
  logic [CntW-1:0]                      w_num_survivors;
  logic [PLAYER_W-1:0]                  w_survivor;
  logic                                 w_all_locked;
  logic                                 w_new_game;
  logic                                 w_enter_select;
  logic                                 w_timer_en;
  logic                                 w_sec_pulse;
  logic                                 w_last_second;
  logic                                 w_time_out;

  assign w_choice = i_choice;

  always_comb begin
    w_alive         = '0;
    w_lock_next     = r_lock;
    w_lives_scored  = r_lives;
    w_num_survivors = '0;
    w_survivor      = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_alive[p] = (r_lives[p] != '0);
      if (i_choice_valid[p] && w_alive[p]) begin
        w_lock_next[p] = 1'b1;
      end
      if (w_alive[p] && (!r_lock[p] || (r_pick[p] != r_door))) begin
        w_lives_scored[p] = r_lives[p] - LIFE_W'(1);
      end
      if (w_lives_scored[p] != '0) begin
        w_num_survivors = w_num_survivors + CntW'(1);
        w_survivor      = PLAYER_W'(p);
      end
    end
    // Includes this cycle's strobes so the last lock ends the round immediately.
    w_all_locked = ((w_lock_next & w_alive) == w_alive);
  end

  assign w_new_game     = i_start && ((r_state == StIdle) || (r_state == StGameOver));
  assign w_enter_select = w_new_game ||
                          ((r_state == StScore) && (w_num_survivors > CntW'(1)));
  assign w_timer_en     = (r_state == StSelect);
  assign w_time_out     = w_sec_pulse && w_last_second;

  round_timer #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .ROUND_SECONDS (ROUND_SECONDS)
  ) u_round_timer (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_load         (w_enter_select),
    .i_enable       (w_timer_en),
    .o_sec_pulse    (w_sec_pulse),
    .o_expired      (w_last_second),
    .o_seconds_left (o_seconds_left)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_lfsr    <= LFSR_SEED;
      r_lives   <= {NUM_PLAYERS{LivesInit}};
      r_pick    <= '0;
      r_lock    <= '0;
      r_door    <= '0;
      r_time_up <= 1'b0;
      r_rev_cnt <= '0;
      r_winner  <= '0;
      r_draw    <= 1'b0;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
      case (r_state)
        StIdle, StGameOver: begin
          if (i_start) begin
            r_lives <= {NUM_PLAYERS{LivesInit}};
            r_draw  <= 1'b0;
            r_lock  <= '0;
            r_door  <= r_lfsr[DOOR_W-1:0];
            r_state <= StSelect;
          end
        end
        StSelect: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (i_choice_valid[p] && w_alive[p] && !r_lock[p]) begin
              r_pick[p] <= w_choice[p];
            end
          end
          r_lock <= w_lock_next;
          if (w_time_out || w_all_locked) begin
            r_state   <= StReveal;
            r_time_up <= 1'b1;
            r_rev_cnt <= '0;
          end
        end
        StReveal: begin
          if (r_rev_cnt == RevMax) begin
            r_state   <= StScore;
            r_time_up <= 1'b0;
          end else begin
            r_rev_cnt <= r_rev_cnt + RevW'(1);
          end
        end
        StScore: begin
          r_lives <= w_lives_scored;
          if (w_num_survivors == CntW'(0)) begin
            r_draw  <= 1'b1;
            r_state <= StGameOver;
          end else if (w_num_survivors == CntW'(1)) begin
            r_winner <= w_survivor;
            r_state  <= StGameOver;
          end else begin
            r_lock  <= '0;
            r_door  <= r_lfsr[DOOR_W-1:0];
            r_state <= StSelect;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_lives        = r_lives;
  assign o_correct_door = r_door;
  assign o_time_up      = r_time_up;
  assign o_state        = r_state;
  assign o_winner       = r_winner;
  assign o_draw         = r_draw;

endmodule

// File: tb/tb_door_game_ctrl.sv
// Self-checking bench for door_game_ctrl: directed games plus randomized rounds,
// each round predicted from the game rules before it is played.
module tb_door_game_ctrl;

  localparam int NP   = 2;
  localparam int ND   = 4;
  localparam int ML   = 3;
  localparam int TPS  = 4;
  localparam int RS   = 3;
  localparam int RT   = 8;
  localparam int SIdle = 0, SSelect = 1, SReveal = 2, SScore = 3, SGameOver = 4;

  logic           clk;
  logic           rst_n;
  logic           i_start;
  logic [NP*2-1:0] i_choice;
  logic [NP-1:0]  i_choice_valid;
  logic [NP*2-1:0] o_lives;
  logic [1:0]     o_correct_door;
  logic           o_time_up;
  logic [5:0]     o_seconds_left;
  logic [2:0]     o_state;
  logic           o_winner;
  logic           o_draw;

  door_game_ctrl #(
    .NUM_PLAYERS   (NP),
    .NUM_DOORS     (ND),
    .MAX_LIVES     (ML),
    .TICKS_PER_SEC (TPS),
    .ROUND_SECONDS (RS),
    .REVEAL_TICKS  (RT),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (i_start),
    .i_choice       (i_choice),
    .i_choice_valid (i_choice_valid),
    .o_lives        (o_lives),
    .o_correct_door (o_correct_door),
    .o_time_up      (o_time_up),
    .o_seconds_left (o_seconds_left),
    .o_state        (o_state),
    .o_winner       (o_winner),
    .o_draw         (o_draw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;
  int m_lives[NP];
  int m_door;
  bit m_over;
  int stb_n[NP];
  int stb_c[NP][2];
  int stb_off[NP][2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) edges++;
    #1;
  endtask

  // Register value after n advances from the seed, x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_nth(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic logic [31:0] pack_lives();
    logic [31:0] v;
    v = 0;
    for (int p = 0; p < NP; p++) v = v | (32'(m_lives[p]) << (2 * p));
    return v;
  endfunction

  task automatic set_plan(input int p, input int n, input int c0, input int o0,
                          input int c1, input int o1);
    stb_n[p] = n;
    stb_c[p][0] = c0; stb_off[p][0] = o0;
    stb_c[p][1] = c1; stb_off[p][1] = o1;
  endtask

  task automatic random_plan(input bit quiet);
    for (int p = 0; p < NP; p++) begin
      stb_n[p] = quiet ? 0 : int'($urandom_range(0, 2));
      stb_c[p][0] = int'($urandom_range(0, 13));
      stb_c[p][1] = stb_c[p][0] + 1 + int'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++)
        stb_off[p][k] = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
    end
  endtask

  task automatic start_game();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int p = 0; p < NP; p++) m_lives[p] = ML;
    m_over = 1'b0;
  endtask

  // Called at the first sampled cycle of SELECT; plays the planned round to its end.
  task automatic run_round();
    int  exit_c, surv, last;
    int  new_lives[NP];
    int  pick[NP];
    bit  locked[NP];
    bit  alive[NP];
    bit  everyone;
    int  exp_state;
    m_door = int'(lfsr_nth(edges - 1) & 16'h3);
    check_eq("select_state", o_state, SSelect);
    check_eq("door_at_entry", o_correct_door, m_door);
    check_eq("lives_at_entry", o_lives, pack_lives());
    exit_c = RS * TPS - 1;
    for (int p = 0; p < NP; p++) begin
      locked[p] = 0; pick[p] = 0; alive[p] = (m_lives[p] != 0);
    end
    for (int c = 0; c < RS * TPS; c++) begin
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < stb_n[p]; k++)
          if (alive[p] && !locked[p] && stb_c[p][k] == c) begin
            locked[p] = 1;
            pick[p] = (m_door + stb_off[p][k]) % ND;
          end
      everyone = 1;
      for (int p = 0; p < NP; p++) if (alive[p] && !locked[p]) everyone = 0;
      if (everyone) begin
        exit_c = c;
        break;
      end
    end
    surv = 0; last = 0;
    for (int p = 0; p < NP; p++) begin
      new_lives[p] = m_lives[p];
      if (alive[p] && (!locked[p] || pick[p] != m_door)) new_lives[p]--;
      if (new_lives[p] > 0) begin surv++; last = p; end
    end
    exp_state = (surv >= 2) ? SSelect : SGameOver;

    for (int c = 0; c <= exit_c + RT + 2; c++) begin
      if (c <= exit_c) begin
        check_eq("select_state", o_state, SSelect);
        check_eq("select_secs", o_seconds_left, RS - c / TPS);
        check_eq("select_time_up", o_time_up, 0);
      end else if (c <= exit_c + RT) begin
        check_eq("reveal_state", o_state, SReveal);
        check_eq("reveal_time_up", o_time_up, 1);
        check_eq("reveal_door", o_correct_door, m_door);
        check_eq("reveal_secs", o_seconds_left, RS - (exit_c + 1) / TPS);
      end else if (c == exit_c + RT + 1) begin
        check_eq("score_state", o_state, SScore);
        check_eq("score_time_up", o_time_up, 0);
      end else begin
        for (int p = 0; p < NP; p++) m_lives[p] = new_lives[p];
        check_eq("post_score_state", o_state, exp_state);
        check_eq("post_score_lives", o_lives, pack_lives());
        check_eq("post_score_time_up", o_time_up, 0);
        if (surv == 0) check_eq("draw_flag", o_draw, 1);
        if (surv == 1) begin
          check_eq("winner", o_winner, last);
          check_eq("no_draw", o_draw, 0);
        end
        break;
      end
      i_choice_valid = '0;
      i_choice = NP'($urandom) == 0 ? '0 : (NP * 2)'($urandom);
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < stb_n[p]; k++)
          if (stb_c[p][k] == c) begin
            i_choice_valid[p] = 1'b1;
            i_choice[2*p +: 2] = 2'((m_door + stb_off[p][k]) % ND);
          end
      i_start = ($urandom_range(0, 7) == 0);
      tick();
    end
    i_start = 1'b0;
    i_choice_valid = '0;
    m_over = (surv < 2);
  endtask

  task automatic check_hold();
    repeat (2) tick();
    check_eq("over_hold_state", o_state, SGameOver);
    check_eq("over_hold_lives", o_lives, pack_lives());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rounds;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_choice = '0;
    i_choice_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("in_reset_state", o_state, SIdle);
    rst_n = 1'b1;
    edges = 0;
    tick();
    check_eq("reset_state", o_state, SIdle);
    check_eq("reset_lives", o_lives, 4'b1111);
    check_eq("reset_time_up", o_time_up, 0);
    check_eq("reset_secs", o_seconds_left, RS);
    check_eq("reset_door", o_correct_door, 0);
    check_eq("reset_winner", o_winner, 0);
    check_eq("reset_draw", o_draw, 0);
    repeat (3) tick();
    check_eq("idle_holds", o_state, SIdle);

    // Game 1: P1 is wrong three rounds running while P0 is always right.
    start_game();
    set_plan(0, 1, 1, 0, 0, 0); set_plan(1, 1, 2, 1, 0, 0); run_round();
    set_plan(0, 1, 6, 0, 0, 0); set_plan(1, 2, 1, 2, 3, 0); run_round();
    set_plan(0, 1, 2, 0, 0, 0); set_plan(1, 0, 0, 0, 0, 0); run_round();
    check_eq("game1_over", m_over, 1);
    check_eq("game1_lives", o_lives, 4'b0011);
    check_hold();

    // Game 2: two silent rounds then both wrong at one life -> draw.
    start_game();
    check_eq("restart_lives", o_lives, 4'b1111);
    set_plan(0, 0, 0, 0, 0, 0); set_plan(1, 0, 0, 0, 0, 0); run_round();
    run_round();
    set_plan(0, 1, 0, 1, 0, 0); set_plan(1, 1, 5, 3, 0, 0); run_round();
    check_eq("game2_draw", o_draw, 1);
    check_hold();

    for (int g = 0; g < 6; g++) begin
      start_game();
      rounds = 0;
      while (!m_over) begin
        random_plan(rounds >= 10);
        run_round();
        rounds++;
      end
      check_hold();
    end

    // Reset in the middle of a reveal.
    start_game();
    for (int n = 0; n < 40 && o_time_up !== 1'b1; n++) tick();
    check_eq("reveal_reached", o_time_up, 1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_state", o_state, SIdle);
    check_eq("abort_time_up", o_time_up, 0);
    check_eq("abort_lives", o_lives, 4'b1111);
    check_eq("abort_secs", o_seconds_left, RS);
    check_eq("abort_draw", o_draw, 0);
    tick();
    rst_n = 1'b1;
    edges = 0;
    tick();
    check_eq("after_abort_state", o_state, SIdle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/door_game_ctrl.md
Name: door_game_ctrl

Overview:
Parametrised round controller for the door-guessing game. It generates per-player lives, the correct door and the time_up reveal flag, replacing the static switch-driven values that currently feed screen_drawer. It sits between the serial/choice decoder and screen_drawer, and runs on the VGA pixel clock domain. It owns a round timer, a pseudo-random door picker and the game state machine.

Parameters:
NUM_PLAYERS, 2, number of players (2..4)
NUM_DOORS, 4, number of doors; power of two, 2..8
MAX_LIVES, 3, lives per player at game start (1..7)
TICKS_PER_SEC, 25000000, clk cycles per second of round time
ROUND_SECONDS, 10, selection window per round (1..63)
REVEAL_TICKS, 50000000, clk cycles that the reveal stays on screen
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  in  1  pixel clock; the block's only clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts a game from IDLE or GAME_OVER
choice  in  NUM_PLAYERS*DOOR_W  per-player door index, packed, player 0 in the LSBs
choice_valid  in  NUM_PLAYERS  per-player strobe qualifying choice
lives  out  NUM_PLAYERS*LIFE_W  per-player remaining lives, packed
correct_door  out  DOOR_W  door drawn for the current round
time_up  out  1  high during REVEAL
seconds_left  out  6  countdown value for display
state  out  3  encoded FSM state
winner  out  PLAYER_W  index of the surviving player; valid in GAME_OVER
draw  out  1  in GAME_OVER, all players eliminated in the same round

Behaviour:
- Width rules: DOOR_W=$clog2(NUM_DOORS), LIFE_W=$clog2(MAX_LIVES+1), PLAYER_W=max(1,$clog2(NUM_PLAYERS)).
- Reset (asynchronous, active-low):
  - state=IDLE, lives=all MAX_LIVES, correct_door=0, time_up=0, seconds_left=ROUND_SECONDS.
  - winner=0, draw=0, LFSR=LFSR_SEED, all choice locks cleared.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state.
  - correct_door = LFSR[DOOR_W-1:0], sampled on the cycle the FSM enters SELECT.
- FSM states: IDLE, SELECT, REVEAL, SCORE, GAME_OVER.
- IDLE:
  - On start: lives reload to MAX_LIVES, draw=0, go to SELECT.
- SELECT:
  - Entry clears locks, tick counter=0, seconds_left=ROUND_SECONDS.
  - The tick counter wraps at TICKS_PER_SEC-1; each wrap decrements seconds_left.
  - Choice locking: choice_valid[p] with lives[p]!=0 and no lock yet latches choice[p] and sets lock[p]. Later strobes in the same round are ignored. Strobes from eliminated players are ignored.
  - Exit to REVEAL, setting time_up=1 on the next cycle, when either:
    - a wrap happens with seconds_left==1 (seconds_left becomes 0), or
    - every alive player is locked.
  - If both exit conditions occur in the same cycle, take a single transition.
- REVEAL:
  - time_up=1 for exactly REVEAL_TICKS cycles, then go to SCORE.
  - correct_door is held stable.
- SCORE (exactly 1 cycle):
  - Each alive player with no lock, or with a locked choice != correct_door, loses 1 life. Lives saturate at 0.
  - Count survivors after the update:
    - 0 survivors: draw=1, go to GAME_OVER.
    - 1 survivor: winner=that index, go to GAME_OVER.
    - Otherwise go to SELECT.
  - time_up=0 from SCORE onward.
- GAME_OVER:
  - lives, winner and draw hold.
  - On start: reload as in IDLE and go to SELECT.
- start is ignored in SELECT, REVEAL and SCORE.
- Reset mid-round aborts immediately to IDLE with reset values; no partial scoring occurs.

Decomposition:
- Package door_game_pkg holds:
  - the state_t enum (IDLE=0, SELECT=1, REVEAL=2, SCORE=3, GAME_OVER=4),
  - the LFSR tap constant,
  - functions for DOOR_W, LIFE_W and PLAYER_W.
- One sub-module, round_timer, owns the tick counter and seconds_left. Its interface is load, enable, sec_pulse and expired.
- The LFSR, lock registers and FSM stay in door_game_ctrl.

Test Plan:
All scenarios use TICKS_PER_SEC=4, ROUND_SECONDS=3, REVEAL_TICKS=8 and default player/door counts.
- Reset then release -> lives=0b11_11, state=IDLE, time_up=0, seconds_left=3; start pulse -> state=SELECT the next cycle, correct_door equals the LFSR low 2 bits at entry.
- In SELECT, P0 chooses correct_door and P1 chooses a wrong door -> early REVEAL (time_up=1 for 8 cycles) -> SCORE -> lives P0=3, P1=2 -> back to SELECT.
- No choices made -> seconds_left steps 3,2,1,0 every 4 cycles; REVEAL starts 12 cycles after SELECT entry; both players lose a life.
- P1 sends two strobes, the first wrong and the second correct -> only the first is locked; P1 loses a life.
- P1 wrong for 3 rounds while P0 is always correct -> GAME_OVER with winner=0, draw=0, lives=0b00_11; start -> lives back to 0b11_11 and SELECT.
- Both players at 1 life and both wrong -> GAME_OVER with draw=1. Separately, reset asserted mid-REVEAL -> immediate IDLE with time_up=0 and lives reloaded.
